fp_wb_arbiter: RTL and testbench

Writeback arbiter for the FP unit. It takes results from the FP comparison stage and the FP arithmetic stage and merges them into one buffered writeback port toward the register files. It also keeps the sticky `fflags` exception accumulator.

- Comparison results (0/1 plus NV flag) go to the integer file.
- Arithmetic results go to the FP file.

---
 rtl/fp_wb_arbiter_if.sv | 56 +++++
 rtl/fp_wb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_fp_wb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_wb_arbiter_if.sv
// fp_wb_arbiter_if: bundles the two result producers, the writeback consumer
// and the fflags CSR path of the FP writeback arbiter.
//   slave  : arbiter-side view (takes results, drives readys/writeback/flags)
//   master : environment-side view (drives results, consumes writeback)
interface fp_wb_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_WIDTH   = 5
);
    // comparison result channel (integer file)
    logic                  in_cmp_valid;
    logic                  out_cmp_ready;
    logic [DATA_WIDTH-1:0] in_cmp_data;
    logic                  in_cmp_flag_NV;
    logic [RD_WIDTH-1:0]   in_cmp_rd;

    // arithmetic result channel (FP file)
    logic                  in_arith_valid;
    logic                  out_arith_ready;
    logic [DATA_WIDTH-1:0] in_arith_data;
    logic [4:0]            in_arith_flags;
    logic [RD_WIDTH-1:0]   in_arith_rd;

    // buffered writeback port
    logic                  out_wb_valid;
    logic                  in_wb_ready;
    logic [DATA_WIDTH-1:0] out_wb_data;
    logic [RD_WIDTH-1:0]   out_wb_rd;
    logic                  out_wb_is_int;

    // fflags CSR access
    logic                  in_csr_we;
    logic [4:0]            in_csr_wdata;
    logic [4:0]            out_fflags;

    modport slave (
        input  in_cmp_valid, in_cmp_data, in_cmp_flag_NV, in_cmp_rd,
        output out_cmp_ready,
        input  in_arith_valid, in_arith_data, in_arith_flags, in_arith_rd,
        output out_arith_ready,
        output out_wb_valid, out_wb_data, out_wb_rd, out_wb_is_int,
        input  in_wb_ready,
        input  in_csr_we, in_csr_wdata,
        output out_fflags
    );

    modport master (
        output in_cmp_valid, in_cmp_data, in_cmp_flag_NV, in_cmp_rd,
        input  out_cmp_ready,
        output in_arith_valid, in_arith_data, in_arith_flags, in_arith_rd,
        input  out_arith_ready,
        input  out_wb_valid, out_wb_data, out_wb_rd, out_wb_is_int,
        output in_wb_ready,
        output in_csr_we, in_csr_wdata,
        input  out_fflags
    );
endinterface

// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: merges FP comparison results (integer file) and FP arithmetic
// results (FP file) into one buffered writeback port, round-robin arbitrated,
// and keeps the sticky fflags accumulator.
// Build option: define FP_WB_SKID_EN for a 2-entry output buffer that keeps
// accepting while the head is stalled; otherwise the buffer holds 1 entry.
module fp_wb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_WIDTH   = 5
) (
    input  logic           in_clk,
    input  logic           in_rst_n,
    fp_wb_arbiter_if.slave bus
);

`ifdef FP_WB_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // which channel wins a tie
    typedef enum logic {
        PRI_CMP   = 1'b0,
        PRI_ARITH = 1'b1
    } pri_e;

    // circular pointer advance with wrap at DEPTH
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // state
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    pri_e                  pri_q, pri_d;
    logic [4:0]            fflags_q, fflags_d;
    logic [DATA_WIDTH-1:0] data_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_d   [DEPTH];
    logic [RD_WIDTH-1:0]   rd_q     [DEPTH];
    logic [RD_WIDTH-1:0]   rd_d     [DEPTH];
    logic                  is_int_q [DEPTH];
    logic                  is_int_d [DEPTH];

    // arbitration / datapath intermediates
    logic                  pop;
    logic                  can_accept;
    logic                  cmp_x0;
    logic                  cmp_elig;
    logic                  arith_elig;
    logic                  grant_cmp;
    logic                  grant_arith;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic [RD_WIDTH-1:0]   push_rd;
    logic                  push_is_int;
    logic [4:0]            acc_flags;
    logic [DEPTH-1:0]      wr_en;

    // Grant decision. A comparison aimed at x0 never occupies a slot, so it
    // stays eligible even when the buffer is full and not draining. Both
    // readys are forced low while reset is asserted.
    always_comb begin
        pop         = (count_q != '0) && bus.in_wb_ready;
        can_accept  = (count_q < DEPTH_C) || pop;
        cmp_x0      = (bus.in_cmp_rd == '0);
        cmp_elig    = in_rst_n && bus.in_cmp_valid && (can_accept || cmp_x0);
        arith_elig  = in_rst_n && bus.in_arith_valid && can_accept;
        grant_cmp   = cmp_elig   && (!arith_elig || (pri_q == PRI_CMP));
        grant_arith = arith_elig && (!cmp_elig   || (pri_q == PRI_ARITH));

        push        = grant_arith || (grant_cmp && !cmp_x0);
        push_data   = grant_cmp ? bus.in_cmp_data : bus.in_arith_data;
        push_rd     = grant_cmp ? bus.in_cmp_rd   : bus.in_arith_rd;
        push_is_int = grant_cmp;

        acc_flags = 5'b00000;
        if (grant_cmp) begin
            acc_flags = {bus.in_cmp_flag_NV, 4'b0000};
        end else if (grant_arith) begin
            acc_flags = bus.in_arith_flags;
        end
    end

    assign bus.out_cmp_ready   = grant_cmp;
    assign bus.out_arith_ready = grant_arith;

    // per-slot write enables from the write pointer
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    // Next-state: occupancy, pointers, priority, flags and slot contents
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        pri_d    = pri_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        // the loser of this cycle gets priority next time
        if (grant_cmp) begin
            pri_d = PRI_ARITH;
        end else if (grant_arith) begin
            pri_d = PRI_CMP;
        end

        // CSR write replaces the base value; new exceptions are still ORed in
        fflags_d = (bus.in_csr_we ? bus.in_csr_wdata : fflags_q) | acc_flags;

        for (int i = 0; i < DEPTH; i++) begin
            data_d[i]   = data_q[i];
            rd_d[i]     = rd_q[i];
            is_int_d[i] = is_int_q[i];
            if (wr_en[i]) begin
                data_d[i]   = push_data;
                rd_d[i]     = push_rd;
                is_int_d[i] = push_is_int;
            end
        end
    end

    // State register with synchronous active-low reset; storage is cleared
    // too so the writeback port reads all-zero after reset.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            pri_q    <= PRI_CMP;
            fflags_q <= 5'b00000;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]   <= '0;
                rd_q[i]     <= '0;
                is_int_q[i] <= 1'b0;
            end
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            pri_q    <= pri_d;
            fflags_q <= fflags_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]   <= data_d[i];
                rd_q[i]     <= rd_d[i];
                is_int_q[i] <= is_int_d[i];
            end
        end
    end

    // Head of the buffer drives the writeback port
    generate
        if (DEPTH == 1) begin : g_head_single
            assign bus.out_wb_data   = data_q[0];
            assign bus.out_wb_rd     = rd_q[0];
            assign bus.out_wb_is_int = is_int_q[0];
        end else begin : g_head_multi
            assign bus.out_wb_data   = data_q[rd_ptr_q];
            assign bus.out_wb_rd     = rd_q[rd_ptr_q];
            assign bus.out_wb_is_int = is_int_q[rd_ptr_q];
        end
    endgenerate

    assign bus.out_wb_valid = (count_q != '0);
    assign bus.out_fflags   = fflags_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb_fp_wb_arbiter: directed test of fp_wb_arbiter. Stimulus pushes expected
// writeback entries into a queue; a monitor compares each popped entry.
module tb_fp_wb_arbiter;
    localparam int DW = 64;
    localparam int RW = 5;
`ifdef FP_WB_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] rd;
        logic          is_int;
    } wb_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_wb_arbiter_if #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) bus ();

    fp_wb_arbiter #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    function automatic wb_t mk(input logic [DW-1:0] d, input logic [RW-1:0] r, input logic i);
        wb_t e;
        e.data   = d;
        e.rd     = r;
        e.is_int = i;
        return e;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every writeback handshake is compared against the queue head
    always @(negedge clk) begin
        wb_t act;
        wb_t exp;
        if (rst_n && bus.out_wb_valid && bus.in_wb_ready) begin
            act = mk(bus.out_wb_data, bus.out_wb_rd, bus.out_wb_is_int);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got data=%0h rd=%0d is_int=%0b expected no entry",
                         act.data, act.rd, act.is_int);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL wb_entry: got data=%0h rd=%0d is_int=%0b expected data=%0h rd=%0d is_int=%0b",
                             act.data, act.rd, act.is_int, exp.data, exp.rd, exp.is_int);
                end else begin
                    $display("wb pop: data=%0h rd=%0d is_int=%0b", act.data, act.rd, act.is_int);
                end
            end
        end
    end

    // Absolute guard against a hung run
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t expected < 200000", $time);
        $fatal(1, "timeout");
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.in_wb_ready = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "_empty_after"}, bus.out_wb_valid, 1'b0);
    endtask

    // Fill the buffer with DEPTH arith entries while the consumer stalls
    task automatic fill(input logic [DW-1:0] base);
        bus.in_wb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            bus.in_arith_valid = 1'b1;
            bus.in_arith_data  = base + DW'(i);
            bus.in_arith_rd    = RW'(20 + i);
            bus.in_arith_flags = 5'b00000;
            @(negedge clk);
            check("fill_arith_ready", bus.out_arith_ready, 1'b1);
            exp_q.push_back(mk(base + DW'(i), RW'(20 + i), 1'b0));
        end
        @(posedge clk); #1;
        bus.in_arith_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [DW-1:0] rr_cmp_d   [2];
    logic [RW-1:0] rr_cmp_rd  [2];
    logic [DW-1:0] rr_ar_d    [2];
    logic [RW-1:0] rr_ar_rd   [2];
    logic [DW-1:0] bp_d       [3];

    initial begin
        int kc;
        int ka;
        logic exp_cmp;

        rr_cmp_d  = '{64'd1, 64'd0};
        rr_cmp_rd = '{5'd3, 5'd4};
        rr_ar_d   = '{64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000};
        rr_ar_rd  = '{5'd0, 5'd9};
        bp_d      = '{64'h11, 64'h22, 64'h33};

        // ---------------- reset with both requesters valid
        bus.in_cmp_valid   = 1'b1;
        bus.in_cmp_data    = '0;
        bus.in_cmp_flag_NV = 1'b0;
        bus.in_cmp_rd      = 5'd1;
        bus.in_arith_valid = 1'b1;
        bus.in_arith_data  = '0;
        bus.in_arith_flags = 5'b00000;
        bus.in_arith_rd    = 5'd1;
        bus.in_wb_ready    = 1'b0;
        bus.in_csr_we      = 1'b0;
        bus.in_csr_wdata   = 5'b00000;
        rst_n              = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_cmp_ready",   bus.out_cmp_ready,   1'b0);
            check("rst_arith_ready", bus.out_arith_ready, 1'b0);
            check("rst_wb_valid",    bus.out_wb_valid,    1'b0);
            check("rst_fflags",      bus.out_fflags,      5'b00000);
            check("rst_wb_is_int",   bus.out_wb_is_int,   1'b0);
            check("rst_wb_data",     bus.out_wb_data,     64'd0);
            check("rst_wb_rd",       bus.out_wb_rd,       5'd0);
        end
        @(posedge clk); #1;
        bus.in_cmp_valid   = 1'b0;
        bus.in_arith_valid = 1'b0;
        rst_n              = 1'b1;

        // ---------------- single comparison
        @(posedge clk); #1;
        bus.in_cmp_valid   = 1'b1;
        bus.in_cmp_data    = 64'd1;
        bus.in_cmp_rd      = 5'd7;
        bus.in_cmp_flag_NV = 1'b1;
        bus.in_wb_ready    = 1'b1;
        @(negedge clk);
        check("single_cmp_ready",   bus.out_cmp_ready,   1'b1);
        check("single_arith_ready", bus.out_arith_ready, 1'b0);
        exp_q.push_back(mk(64'd1, 5'd7, 1'b1));
        @(posedge clk); #1;
        bus.in_cmp_valid   = 1'b0;
        bus.in_cmp_flag_NV = 1'b0;
        @(negedge clk);
        check("single_wb_valid", bus.out_wb_valid, 1'b1);
        check("single_fflags",   bus.out_fflags,   5'b10000);
        drain("single");

        // ---------------- round-robin, priority restarts at cmp after reset
        pulse_reset();
        bus.in_wb_ready = 1'b1;
        kc = 0;
        ka = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.in_cmp_valid   = 1'b1;
            bus.in_cmp_data    = rr_cmp_d[kc % 2];
            bus.in_cmp_rd      = rr_cmp_rd[kc % 2];
            bus.in_cmp_flag_NV = 1'b0;
            bus.in_arith_valid = 1'b1;
            bus.in_arith_data  = rr_ar_d[ka % 2];
            bus.in_arith_rd    = rr_ar_rd[ka % 2];
            bus.in_arith_flags = 5'b00000;
            @(negedge clk);
            exp_cmp = ((i % 2) == 0);
            check("rr_cmp_ready",   bus.out_cmp_ready,   exp_cmp);
            check("rr_arith_ready", bus.out_arith_ready, !exp_cmp);
            if (exp_cmp) begin
                exp_q.push_back(mk(rr_cmp_d[kc % 2], rr_cmp_rd[kc % 2], 1'b1));
                kc++;
            end else begin
                exp_q.push_back(mk(rr_ar_d[ka % 2], rr_ar_rd[ka % 2], 1'b0));
                ka++;
            end
        end
        @(posedge clk); #1;
        bus.in_cmp_valid   = 1'b0;
        bus.in_arith_valid = 1'b0;
        drain("rr");

        // ---------------- backpressure: DEPTH accepts, then ready drops
        bus.in_wb_ready = 1'b0;
        ka = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.in_arith_valid = 1'b1;
            bus.in_arith_data  = bp_d[ka];
            bus.in_arith_rd    = RW'(ka + 1);
            bus.in_arith_flags = 5'b00000;
            @(negedge clk);
            check("bp_arith_ready", bus.out_arith_ready, (i < DEPTH));
            check("bp_cmp_ready",   bus.out_cmp_ready,   1'b0);
            if (i < DEPTH) begin
                exp_q.push_back(mk(bp_d[ka], RW'(ka + 1), 1'b0));
                ka++;
            end
        end
        @(posedge clk); #1;
        bus.in_arith_valid = 1'b0;
        drain("bp");

        // ---------------- x0 comparison while full and stalled
        @(posedge clk); #1;
        bus.in_csr_we    = 1'b1;
        bus.in_csr_wdata = 5'b00000;
        @(posedge clk); #1;
        bus.in_csr_we    = 1'b0;
        fill(64'h100);
        bus.in_cmp_valid   = 1'b1;
        bus.in_cmp_data    = 64'd1;
        bus.in_cmp_rd      = 5'd0;
        bus.in_cmp_flag_NV = 1'b1;
        @(negedge clk);
        check("x0_cmp_ready",  bus.out_cmp_ready, 1'b1);
        check("x0_wb_valid",   bus.out_wb_valid,  1'b1);
        @(posedge clk); #1;
        bus.in_cmp_valid   = 1'b0;
        bus.in_cmp_flag_NV = 1'b0;
        bus.in_arith_valid = 1'b1;
        bus.in_arith_data  = 64'hDEAD;
        bus.in_arith_rd    = 5'd30;
        @(negedge clk);
        check("x0_still_full", bus.out_arith_ready, 1'b0);
        check("x0_fflags",     bus.out_fflags,      5'b10000);
        @(posedge clk); #1;
        bus.in_arith_valid = 1'b0;
        drain("x0");

        // ---------------- CSR write colliding with an arith accept
        @(posedge clk); #1;
        bus.in_wb_ready    = 1'b1;
        bus.in_arith_valid = 1'b1;
        bus.in_arith_data  = 64'h55;
        bus.in_arith_rd    = 5'd12;
        bus.in_arith_flags = 5'b00100;
        bus.in_csr_we      = 1'b1;
        bus.in_csr_wdata   = 5'b00001;
        @(negedge clk);
        check("csr_arith_ready", bus.out_arith_ready, 1'b1);
        exp_q.push_back(mk(64'h55, 5'd12, 1'b0));
        @(posedge clk); #1;
        bus.in_arith_valid = 1'b0;
        bus.in_arith_flags = 5'b00000;
        bus.in_csr_we      = 1'b0;
        @(negedge clk);
        check("csr_fflags", bus.out_fflags, 5'b00101);
        drain("csr");

        // ---------------- reset mid-operation discards buffered entries
        fill(64'h200);
        pulse_reset();
        @(negedge clk);
        check("midrst_wb_valid", bus.out_wb_valid, 1'b0);
        check("midrst_wb_data",  bus.out_wb_data,  64'd0);
        check("midrst_fflags",   bus.out_fflags,   5'b00000);
        bus.in_wb_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
